adder_resp_checker: RTL and testbench

- Synthesizable response checker for the 8-bit ripple/CLA adder family. It is the receiving end of the adder stimulus flow.
- It captures each operand pair sent to the adder DUT and buffers it until the DUT result returns.
- It computes the expected {cout,sum}, compares, and keeps pass/fail statistics.
- It sits beside the DUT in on-board self-test wrappers and in regression benches.

---
 rtl/adder_chk_pkg.sv | 18 +
 rtl/adder_chk_fifo.sv | 58 +++++
 rtl/adder_resp_checker.sv | 192 +++++++++++++++++++
 tb/tb_adder_resp_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types and default sizes for the adder response checker.
package adder_chk_pkg;

  localparam int ADDER_CHK_WIDTH = 8;
  localparam int ADDER_CHK_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  typedef struct packed {
    logic [ADDER_CHK_WIDTH-1:0] a;
    logic [ADDER_CHK_WIDTH-1:0] b;
  } opnd_pair_t;

endpackage

// File: rtl/adder_chk_fifo.sv
// Synchronous FIFO holding operand pairs until the matching DUT result returns.
module adder_chk_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic                          do_push, do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/adder_resp_checker.sv
// Checks 8-bit adder DUT results against buffered operands and keeps statistics.
// Optional first-mismatch capture ports: define ADDER_CHK_FIRST_FAIL_EN.
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH = ADDER_CHK_WIDTH,
  parameter int DEPTH = ADDER_CHK_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             ovf_err,
  output logic             orphan_err
`ifdef ADDER_CHK_FIRST_FAIL_EN
  ,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH:0]   fail_exp,
  output logic [WIDTH:0]   fail_got,
  output logic [CNT_W-1:0] fail_idx
`endif
);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             ovf_q, ovf_d, orphan_q, orphan_d;

  logic               fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] fifo_dout;
  logic [WIDTH-1:0]   head_a, head_b;
  logic [WIDTH:0]     exp_res, got_res;
  logic               run, mismatch;

  assign run      = (state_q == RUN);
  assign head_a   = fifo_dout[2*WIDTH-1:WIDTH];
  assign head_b   = fifo_dout[WIDTH-1:0];
  assign exp_res  = {1'b0, head_a} + {1'b0, head_b};
  assign got_res  = {cout, sum};
  assign mismatch = (got_res != exp_res);

  // Once the target is reached, stray results in the final RUN cycle are not counted.
  assign fifo_push = run && op_valid;
  assign fifo_pop  = run && res_valid && !fifo_empty && (vec_count_q != target_q);

  adder_chk_fifo #(
    .DATA_W (2*WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({a, b}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef ADDER_CHK_FIRST_FAIL_EN
  logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic [WIDTH:0]   fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
  logic [CNT_W-1:0] fail_idx_q, fail_idx_d;
`endif

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    ovf_d       = ovf_q;
    orphan_d    = orphan_q;
    fifo_clr    = 1'b0;
`ifdef ADDER_CHK_FIRST_FAIL_EN
    fail_a_d    = fail_a_q;
    fail_b_d    = fail_b_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    fail_idx_d  = fail_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          target_d    = num_vectors;
          vec_count_d = '0;
          err_count_d = '0;
          ovf_d       = 1'b0;
          orphan_d    = 1'b0;
          fifo_clr    = 1'b1;
`ifdef ADDER_CHK_FIRST_FAIL_EN
          fail_a_d    = '0;
          fail_b_d    = '0;
          fail_exp_d  = '0;
          fail_got_d  = '0;
          fail_idx_d  = '0;
`endif
        end
      end
      RUN: begin
        if (vec_count_q == target_q) state_d = DONE;
        // A pop in the same cycle frees the slot, so only an unmatched full push overflows.
        if (op_valid && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (res_valid && fifo_empty) orphan_d = 1'b1;
        if (fifo_pop) begin
          vec_count_d = vec_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (mismatch && (err_count_q != {CNT_W{1'b1}}))
            err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef ADDER_CHK_FIRST_FAIL_EN
          if (mismatch && (err_count_q == '0)) begin
            fail_a_d   = head_a;
            fail_b_d   = head_b;
            fail_exp_d = exp_res;
            fail_got_d = got_res;
            fail_idx_d = vec_count_q;
          end
`endif
        end
      end
      DONE: begin
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_q    <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      ovf_q       <= 1'b0;
      orphan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      ovf_q       <= ovf_d;
      orphan_q    <= orphan_d;
    end
  end

`ifdef ADDER_CHK_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_exp_q <= '0;
      fail_got_q <= '0;
      fail_idx_q <= '0;
    end else begin
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_exp_q <= fail_exp_d;
      fail_got_q <= fail_got_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign fail_a   = fail_a_q;
  assign fail_b   = fail_b_q;
  assign fail_exp = fail_exp_q;
  assign fail_got = fail_got_q;
  assign fail_idx = fail_idx_q;
`endif

  assign busy       = run;
  assign done       = (state_q == DONE);
  assign pass       = done && (err_count_q == '0) && !ovf_q && !orphan_q;
  assign vec_count  = vec_count_q;
  assign err_count  = err_count_q;
  assign ovf_err    = ovf_q;
  assign orphan_err = orphan_q;

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench for adder_resp_checker with an operand scoreboard model.
module tb_adder_resp_checker;

  localparam int W = 8;
  localparam int D = 4;
  localparam int C = 16;

  logic         clk, rst_n, start, op_valid, res_valid, cout;
  logic [C-1:0] num_vectors;
  logic [W-1:0] a, b, sum;
  logic         busy, done, pass, ovf_err, orphan_err;
  logic [C-1:0] vec_count, err_count;
`ifdef ADDER_CHK_FIRST_FAIL_EN
  logic [W-1:0] fail_a, fail_b;
  logic [W:0]   fail_exp, fail_got;
  logic [C-1:0] fail_idx;
`endif

  adder_resp_checker #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_vectors (num_vectors),
    .op_valid    (op_valid),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .vec_count   (vec_count),
    .err_count   (err_count),
    .ovf_err     (ovf_err),
    .orphan_err  (orphan_err)
`ifdef ADDER_CHK_FIRST_FAIL_EN
    ,
    .fail_a      (fail_a),
    .fail_b      (fail_b),
    .fail_exp    (fail_exp),
    .fail_got    (fail_got),
    .fail_idx    (fail_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {cout,sum} queued at push, consumed at result.
  logic [W:0] mq[$];
  int         mvec, merr;
  bit         movf, morph, mrun;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mvec = 0; merr = 0; movf = 0; morph = 0;
  endtask

  task automatic cyc(input logic st, input logic op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic rv, input logic [W:0] r);
    logic [W:0] e;
    start = st; op_valid = op; a = ia; b = ib; res_valid = rv; {cout, sum} = r;
    if (mrun) begin
      if (rv) begin
        if (mq.size() == 0) morph = 1;
        else begin
          e = mq.pop_front();
          mvec++;
          if (r != e) merr++;
        end
      end
      if (op) begin
        if (mq.size() < D) mq.push_back({1'b0, ia} + {1'b0, ib});
        else movf = 1;
      end
    end
    @(posedge clk); #1;
    start = 0; op_valid = 0; res_valid = 0; a = 0; b = 0; sum = 0; cout = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 8'h00, 8'h00, 0, 9'h000);
  endtask

  task automatic push(input logic [W-1:0] ia, input logic [W-1:0] ib);
    cyc(0, 1, ia, ib, 0, 9'h000);
  endtask

  task automatic res_good();
    cyc(0, 0, 8'h00, 8'h00, 1, mq[0]);
  endtask

  task automatic begin_run(input logic [C-1:0] n);
    num_vectors = n;
    mrun = 0;
    cyc(1, 0, 8'h00, 8'h00, 0, 9'h000);
    model_clear();
    mrun = 1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".vec"}, 32'(vec_count), 32'(mvec));
    check({tag, ".err"}, 32'(err_count), 32'(merr));
    check({tag, ".ovf"}, 32'(ovf_err), 32'(movf));
    check({tag, ".orph"}, 32'(orphan_err), 32'(morph));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".pass"}, 32'(pass), 0);
    check({tag, ".vec"}, 32'(vec_count), 0);
    check({tag, ".err"}, 32'(err_count), 0);
    check({tag, ".ovf"}, 32'(ovf_err), 0);
    check({tag, ".orph"}, 32'(orphan_err), 0);
  endtask

  initial begin
    rst_n = 0; start = 0; num_vectors = 0; op_valid = 0; a = 0; b = 0;
    res_valid = 0; sum = 0; cout = 0; mrun = 0;
    model_clear();
    #12;
    check_zero("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Two correct vectors, including a carry-out wrap.
    begin_run(2);
    check("t1.busy", 32'(busy), 1);
    cyc(1, 0, 8'h00, 8'h00, 0, 9'h000);
    check("t1.start_ignored", 32'(busy), 1);
    push(8'h12, 8'h34);
    cyc(0, 0, 8'h00, 8'h00, 1, 9'h046);
    push(8'hFF, 8'h01);
    cyc(0, 0, 8'h00, 8'h00, 1, 9'h100);
    check_model("t1");
    check("t1.vec2", 32'(vec_count), 2);
    idle();
    check("t1.done", 32'(done), 1);
    check("t1.pass", 32'(pass), 1);
    mrun = 0;
    cyc(1, 0, 8'h00, 8'h00, 0, 9'h000);
    check("t1.idle_busy", 32'(busy), 0);
    check("t1.idle_done", 32'(done), 0);

    // One wrong result.
    begin_run(1);
    push(8'h12, 8'h34);
    cyc(0, 0, 8'h00, 8'h00, 1, 9'h047);
    check_model("t2");
    check("t2.err1", 32'(err_count), 1);
    idle();
    check("t2.done", 32'(done), 1);
    check("t2.pass", 32'(pass), 0);
`ifdef ADDER_CHK_FIRST_FAIL_EN
    check("t2.fexp", 32'(fail_exp), 32'h046);
    check("t2.fgot", 32'(fail_got), 32'h047);
    check("t2.fidx", 32'(fail_idx), 0);
    check("t2.fa", 32'(fail_a), 32'h12);
`endif
    mrun = 0;
    cyc(1, 0, 8'h00, 8'h00, 0, 9'h000);

    // Overflow: five pushes into a four-deep buffer.
    begin_run(4);
    push(8'h80, 8'h80);
    push(8'h7F, 8'h01);
    push(8'hAA, 8'h55);
    push(8'h01, 8'h02);
    check("t3.ovf4", 32'(ovf_err), 0);
    push(8'h09, 8'h09);
    check("t3.ovf5", 32'(ovf_err), 1);
    for (int i = 0; i < 4; i++) res_good();
    check_model("t3");
    check("t3.vec4", 32'(vec_count), 4);
    idle();
    check("t3.done", 32'(done), 1);
    check("t3.pass", 32'(pass), 0);
    mrun = 0;
    cyc(1, 0, 8'h00, 8'h00, 0, 9'h000);

    // Orphan result with an empty buffer.
    begin_run(1);
    cyc(0, 0, 8'h00, 8'h00, 1, 9'h005);
    check("t4.orph", 32'(orphan_err), 1);
    check("t4.vec0", 32'(vec_count), 0);
    push(8'h05, 8'h06);
    res_good();
    check_model("t4");
    idle();
    check("t4.done", 32'(done), 1);
    check("t4.pass", 32'(pass), 0);
    mrun = 0;
    cyc(1, 0, 8'h00, 8'h00, 0, 9'h000);

    // Push and pop together while full: no overflow, occupancy stays at four.
    begin_run(5);
    push(8'h80, 8'h80);
    push(8'h7F, 8'h01);
    push(8'hAA, 8'h55);
    push(8'h01, 8'h02);
    cyc(0, 1, 8'h10, 8'h20, 1, mq[0]);
    check("t5.ovf_pp", 32'(ovf_err), 0);
    check("t5.vec1", 32'(vec_count), 1);
    push(8'h33, 8'h44);
    check("t5.still_full", 32'(ovf_err), 1);
    for (int i = 0; i < 4; i++) res_good();
    check_model("t5");
    idle();
    check("t5.done", 32'(done), 1);
    mrun = 0;
    cyc(0, 1, 8'h01, 8'h01, 1, 9'h002);
    check("t5.after_done_vec", 32'(vec_count), 5);
    check("t5.after_done_orph", 32'(orphan_err), 0);
    cyc(1, 0, 8'h00, 8'h00, 0, 9'h000);

    // Asynchronous reset mid-run, then a clean single-vector run.
    begin_run(5);
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    res_good();
    res_good();
    check("t6.vec2", 32'(vec_count), 2);
    #2 rst_n = 0;
    #1;
    check_zero("t6.async");
    @(posedge clk); #1;
    rst_n = 1;
    mrun = 0;
    model_clear();
    begin_run(1);
    push(8'hC8, 8'h64);
    res_good();
    check_model("t6b");
    idle();
    check("t6b.done", 32'(done), 1);
    check("t6b.pass", 32'(pass), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
